// File: rtl/lm32_dtlb_walker_pkg.sv
// Shared definitions for the LM32 data-TLB hardware page-table walker.
package lm32_dtlb_walker_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_UPDATE = 2'd2,
        S_FAULT  = 2'd3
    } walk_state_t;

    typedef enum logic [1:0] {
        FAULT_NOT_PRESENT   = 2'd0,
        FAULT_WRITE_PROTECT = 2'd1,
        FAULT_BUS_ERROR     = 2'd2,
        FAULT_TIMEOUT       = 2'd3
    } fault_cause_t;

    // PTE flag bit positions; the PFN occupies [31:offset_w]
    localparam int unsigned PTE_VALID_BIT    = 0;
    localparam int unsigned PTE_WRITABLE_BIT = 1;

endpackage

// File: rtl/lm32_dtlb_walker.sv
// Single-level hardware refill engine for the LM32 data TLB: on a miss it
// fetches one PTE over a read-only Wishbone master and either writes the
// translation into the DTLB or raises a fault strobe.
module lm32_dtlb_walker
    import lm32_dtlb_walker_pkg::*;
#(
    parameter int unsigned page_size = 4096,
    parameter int unsigned timeout   = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable,
    input  logic        abort_i,
    input  logic [31:0] ptbr_i,
    input  logic        miss_i,
    input  logic [31:0] miss_addr_i,
    input  logic        miss_store_i,
    output logic [31:0] wb_adr_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic [3:0]  wb_sel_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    output logic        busy_o,
    output logic        update_o,
    output logic [31:0] update_vaddr_o,
    output logic [31:0] update_paddr_o,
    output logic        fault_o,
    output logic [1:0]  fault_cause_o,
    output logic [31:0] fault_addr_o
);

    localparam int unsigned offset_w = $clog2(page_size);
    localparam int unsigned vpn_w    = 32 - offset_w;

    walk_state_t  state, state_next;
    fault_cause_t cause_next;
    logic         start;
    logic         armed;
    logic         store;
    logic [31:0]  vaddr;
    logic [7:0]   count;

    // Low PTBR bits and PTE bits between the flags and the PFN carry no meaning
    logic unused_bits;
    assign unused_bits = ^{ptbr_i[vpn_w+1:0], wb_dat_i[offset_w-1:2]};

    assign wb_sel_o = 4'hF;

    // Next-state selection, exit priority in FETCH, and abort-gated strobes
    always_comb begin
        state_next = state;
        cause_next = FAULT_NOT_PRESENT;
        start      = 1'b0;
        update_o   = 1'b0;
        fault_o    = 1'b0;
        case (state)
            S_IDLE: begin
                if (enable && miss_i && armed && !abort_i) begin
                    state_next = S_FETCH;
                    start      = 1'b1;
                end
            end
            S_FETCH: begin
                if (abort_i || !enable) begin
                    state_next = S_IDLE;
                end else if (wb_err_i) begin
                    state_next = S_FAULT;
                    cause_next = FAULT_BUS_ERROR;
                end else if (wb_ack_i && !wb_dat_i[PTE_VALID_BIT]) begin
                    state_next = S_FAULT;
                    cause_next = FAULT_NOT_PRESENT;
                end else if (wb_ack_i && store && !wb_dat_i[PTE_WRITABLE_BIT]) begin
                    state_next = S_FAULT;
                    cause_next = FAULT_WRITE_PROTECT;
                end else if (wb_ack_i) begin
                    state_next = S_UPDATE;
                end else if (count == 8'(timeout - 1)) begin
                    state_next = S_FAULT;
                    cause_next = FAULT_TIMEOUT;
                end
            end
            S_UPDATE: begin
                state_next = S_IDLE;
                update_o   = !abort_i;
            end
            S_FAULT: begin
                state_next = S_IDLE;
                fault_o    = !abort_i;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State register plus walk context, bus signals and held result fields
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= S_IDLE;
            armed          <= 1'b1;
            store          <= 1'b0;
            vaddr          <= '0;
            count          <= '0;
            busy_o         <= 1'b0;
            wb_adr_o       <= '0;
            wb_cyc_o       <= 1'b0;
            wb_stb_o       <= 1'b0;
            update_vaddr_o <= '0;
            update_paddr_o <= '0;
            fault_cause_o  <= '0;
            fault_addr_o   <= '0;
        end else begin
            state  <= state_next;
            busy_o <= (state_next != S_IDLE);

            if (start) begin
                armed <= 1'b0;
            end else if (!miss_i) begin
                armed <= 1'b1;
            end

            if (start) begin
                vaddr    <= miss_addr_i;
                store    <= miss_store_i;
                count    <= '0;
                wb_adr_o <= {ptbr_i[31:vpn_w+2], miss_addr_i[31:offset_w], 2'b00};
                wb_cyc_o <= 1'b1;
                wb_stb_o <= 1'b1;
            end else if (state == S_FETCH) begin
                count <= count + 8'd1;
                if (state_next != S_FETCH) begin
                    wb_cyc_o <= 1'b0;
                    wb_stb_o <= 1'b0;
                end
            end

            if (state == S_FETCH && state_next == S_UPDATE) begin
                update_vaddr_o <= {vaddr[31:offset_w], {offset_w{1'b0}}};
                update_paddr_o <= {wb_dat_i[31:offset_w], {offset_w{1'b0}}};
            end

            if (state == S_FETCH && state_next == S_FAULT) begin
                fault_cause_o <= cause_next;
                fault_addr_o  <= vaddr;
            end
        end
    end

endmodule

// File: tb/tb_lm32_dtlb_walker.sv
// Self-checking bench for lm32_dtlb_walker: directed scenarios plus random
// walks checked against an arithmetic model of the page-table rules.
module tb_lm32_dtlb_walker;

    localparam int unsigned PAGE = 4096;
    localparam int unsigned TMO  = 255;
    localparam int unsigned OFFW = $clog2(PAGE);
    localparam int unsigned VPNW = 32 - OFFW;

    localparam int RESP_ACK  = 0;
    localparam int RESP_ERR  = 1;
    localparam int RESP_BOTH = 2;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        enable = 1'b0;
    logic        abort_i = 1'b0;
    logic [31:0] ptbr_i = '0;
    logic        miss_i = 1'b0;
    logic [31:0] miss_addr_i = '0;
    logic        miss_store_i = 1'b0;
    logic [31:0] wb_adr_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_i = '0;
    logic        wb_ack_i = 1'b0;
    logic        wb_err_i = 1'b0;
    logic        busy_o;
    logic        update_o;
    logic [31:0] update_vaddr_o;
    logic [31:0] update_paddr_o;
    logic        fault_o;
    logic [1:0]  fault_cause_o;
    logic [31:0] fault_addr_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lm32_dtlb_walker #(.page_size(PAGE), .timeout(TMO)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .enable         (enable),
        .abort_i        (abort_i),
        .ptbr_i         (ptbr_i),
        .miss_i         (miss_i),
        .miss_addr_i    (miss_addr_i),
        .miss_store_i   (miss_store_i),
        .wb_adr_o       (wb_adr_o),
        .wb_cyc_o       (wb_cyc_o),
        .wb_stb_o       (wb_stb_o),
        .wb_sel_o       (wb_sel_o),
        .wb_dat_i       (wb_dat_i),
        .wb_ack_i       (wb_ack_i),
        .wb_err_i       (wb_err_i),
        .busy_o         (busy_o),
        .update_o       (update_o),
        .update_vaddr_o (update_vaddr_o),
        .update_paddr_o (update_paddr_o),
        .fault_o        (fault_o),
        .fault_cause_o  (fault_cause_o),
        .fault_addr_o   (fault_addr_o)
    );

    typedef struct {
        logic [31:0] adr;
        logic        is_fault;
        logic [31:0] cause;
        logic [31:0] vpage;
        logic [31:0] ppage;
    } expect_t;

    // Expected walk result from the page-table rules, using plain arithmetic
    function automatic expect_t model(input logic [31:0] ptbr, input logic [31:0] va,
                                      input logic st, input logic [31:0] pte, input int resp);
        expect_t e;
        logic [31:0] base;
        logic [31:0] vpn;
        base  = (ptbr >> (VPNW + 2)) << (VPNW + 2);
        vpn   = va / PAGE;
        e.adr   = base + vpn * 4;
        e.vpage = vpn * PAGE;
        e.ppage = (pte / PAGE) * PAGE;
        if (resp != RESP_ACK) begin
            e.is_fault = 1'b1; e.cause = 2;
        end else if (pte % 2 == 0) begin
            e.is_fault = 1'b1; e.cause = 0;
        end else if (st && ((pte / 2) % 2 == 0)) begin
            e.is_fault = 1'b1; e.cause = 1;
        end else begin
            e.is_fault = 1'b0; e.cause = 0;
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Launch a walk and leave the DUT in FETCH with the request checked
    task automatic start_walk(input logic [31:0] ptbr, input logic [31:0] va,
                              input logic st, input string tag);
        expect_t e;
        e = model(ptbr, va, st, 32'h1, RESP_ACK);
        ptbr_i = ptbr; miss_addr_i = va; miss_store_i = st; miss_i = 1'b1;
        tick;
        check({tag, "_cyc"},  32'(wb_cyc_o), 1);
        check({tag, "_stb"},  32'(wb_stb_o), 1);
        check({tag, "_adr"},  wb_adr_o, e.adr);
        check({tag, "_busy"}, 32'(busy_o), 1);
        // Request fields must be latched, not follow the inputs
        ptbr_i = $urandom; miss_addr_i = $urandom; miss_store_i = ~st;
    endtask

    task automatic finish_idle;
        miss_i = 1'b0;
        tick;
    endtask

    // Complete walk with a bus response after `delay` wait cycles
    task automatic walk(input logic [31:0] ptbr, input logic [31:0] va, input logic st,
                        input logic [31:0] pte, input int unsigned delay, input int resp,
                        input string tag);
        expect_t e;
        e = model(ptbr, va, st, pte, resp);
        start_walk(ptbr, va, st, tag);
        for (int unsigned d = 0; d < delay; d++) begin
            tick;
            check({tag, "_wait_cyc"}, 32'(wb_cyc_o), 1);
            check({tag, "_wait_adr"}, wb_adr_o, e.adr);
        end
        wb_dat_i = pte;
        wb_ack_i = (resp != RESP_ERR);
        wb_err_i = (resp != RESP_ACK);
        tick;
        wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = $urandom;
        check({tag, "_upd"},   32'(update_o), 32'(!e.is_fault));
        check({tag, "_flt"},   32'(fault_o),  32'(e.is_fault));
        check({tag, "_cyc0"},  32'(wb_cyc_o), 0);
        check({tag, "_stb0"},  32'(wb_stb_o), 0);
        check({tag, "_busy1"}, 32'(busy_o),   1);
        if (e.is_fault) begin
            check({tag, "_cause"}, 32'(fault_cause_o), e.cause);
            check({tag, "_faddr"}, fault_addr_o, va);
        end else begin
            check({tag, "_vaddr"}, update_vaddr_o, e.vpage);
            check({tag, "_paddr"}, update_paddr_o, e.ppage);
        end
        tick;
        check({tag, "_upd_end"}, 32'(update_o), 0);
        check({tag, "_flt_end"}, 32'(fault_o),  0);
        check({tag, "_busy0"},   32'(busy_o),   0);
        // miss_i still high: no second walk may start
        tick;
        check({tag, "_norewalk"}, 32'(wb_cyc_o), 0);
        check({tag, "_noretry_busy"}, 32'(busy_o), 0);
        finish_idle;
    endtask

    initial begin
        // Reset state
        tick; tick;
        check("rst_cyc",  32'(wb_cyc_o), 0);
        check("rst_stb",  32'(wb_stb_o), 0);
        check("rst_adr",  wb_adr_o, 0);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_upd",  32'(update_o), 0);
        check("rst_flt",  32'(fault_o), 0);
        check("rst_uva",  update_vaddr_o, 0);
        check("rst_upa",  update_paddr_o, 0);
        check("rst_fca",  32'(fault_cause_o), 0);
        check("rst_fad",  fault_addr_o, 0);
        check("sel",      32'(wb_sel_o), 32'hF);
        rst_i = 1'b0; enable = 1'b1;
        tick;

        // Reference load walk with literal expectations
        walk(32'h0040_0000, 32'h1234_5678, 1'b0, 32'h0ABC_D001, 3, RESP_ACK, "load_ok");
        check("load_ok_adr_lit",   wb_adr_o,       32'h0044_8D14);
        check("load_ok_vaddr_lit", update_vaddr_o, 32'h1234_5000);
        check("load_ok_paddr_lit", update_paddr_o, 32'h0ABC_D000);

        walk(32'h0040_0000, 32'h1234_5678, 1'b0, 32'h0ABC_D000, 2, RESP_ACK,  "not_present");
        check("not_present_cause_lit", 32'(fault_cause_o), 0);
        check("not_present_addr_lit",  fault_addr_o, 32'h1234_5678);
        walk(32'h0040_0000, 32'h1234_5678, 1'b1, 32'h0ABC_D001, 1, RESP_ACK,  "write_prot");
        check("write_prot_cause_lit", 32'(fault_cause_o), 1);
        walk(32'h0040_0000, 32'h1234_5678, 1'b1, 32'h0ABC_D003, 0, RESP_ACK,  "store_ok");
        walk(32'h0040_0000, 32'h1234_5678, 1'b0, 32'h0ABC_D001, 2, RESP_BOTH, "err_ack");
        check("err_ack_cause_lit", 32'(fault_cause_o), 2);

        // Timeout: the last permitted wait cycle still has the request up
        start_walk(32'h0040_0000, 32'h0000_1000, 1'b0, "tmo");
        for (int unsigned i = 1; i < TMO; i++) tick;
        check("tmo_last_cyc", 32'(wb_cyc_o), 1);
        check("tmo_last_flt", 32'(fault_o), 0);
        tick;
        check("tmo_flt",   32'(fault_o), 1);
        check("tmo_cause", 32'(fault_cause_o), 3);
        check("tmo_addr",  fault_addr_o, 32'h0000_1000);
        check("tmo_cyc",   32'(wb_cyc_o), 0);
        tick;
        check("tmo_busy0", 32'(busy_o), 0);
        finish_idle;

        // Abort coincident with a valid PTE ack
        start_walk(32'h0080_0000, 32'hCAFE_0123, 1'b0, "abort_ack");
        tick;
        wb_dat_i = 32'h0ABC_D001; wb_ack_i = 1'b1; abort_i = 1'b1;
        tick;
        wb_ack_i = 1'b0; abort_i = 1'b0;
        check("abort_ack_upd",  32'(update_o), 0);
        check("abort_ack_flt",  32'(fault_o), 0);
        check("abort_ack_cyc",  32'(wb_cyc_o), 0);
        check("abort_ack_busy", 32'(busy_o), 0);
        tick;
        check("abort_ack_upd2", 32'(update_o), 0);
        finish_idle;

        // Abort during the UPDATE / FAULT pulse cycle suppresses the strobe
        for (int k = 0; k < 2; k++) begin
            start_walk(32'h0080_0000, 32'h7000_0004, 1'b0, "abort_pulse");
            wb_dat_i = (k == 0) ? 32'h0000_3001 : 32'h0000_3000; wb_ack_i = 1'b1;
            tick;
            wb_ack_i = 1'b0; abort_i = 1'b1;
            #1;
            check("abort_pulse_upd", 32'(update_o), 0);
            check("abort_pulse_flt", 32'(fault_o), 0);
            tick;
            abort_i = 1'b0;
            check("abort_pulse_busy", 32'(busy_o), 0);
            finish_idle;
        end

        // Enable dropped mid-fetch
        start_walk(32'h0100_0000, 32'h0000_5000, 1'b0, "dis_fetch");
        enable = 1'b0;
        tick;
        check("dis_fetch_cyc",  32'(wb_cyc_o), 0);
        check("dis_fetch_busy", 32'(busy_o), 0);
        check("dis_fetch_upd",  32'(update_o), 0);
        check("dis_fetch_flt",  32'(fault_o), 0);
        finish_idle;

        // Disabled walker ignores misses
        miss_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            check("disabled_cyc",  32'(wb_cyc_o), 0);
            check("disabled_busy", 32'(busy_o), 0);
        end
        miss_i = 1'b0;
        enable = 1'b1;
        tick;

        // Reset asserted during FETCH
        start_walk(32'h0040_0000, 32'h1234_5678, 1'b0, "rst_fetch");
        tick;
        rst_i = 1'b1; wb_ack_i = 1'b1; wb_dat_i = 32'h0ABC_D001;
        tick;
        wb_ack_i = 1'b0;
        check("rst_fetch_cyc",  32'(wb_cyc_o), 0);
        check("rst_fetch_stb",  32'(wb_stb_o), 0);
        check("rst_fetch_adr",  wb_adr_o, 0);
        check("rst_fetch_busy", 32'(busy_o), 0);
        check("rst_fetch_upd",  32'(update_o), 0);
        check("rst_fetch_flt",  32'(fault_o), 0);
        check("rst_fetch_uva",  update_vaddr_o, 0);
        check("rst_fetch_fad",  fault_addr_o, 0);
        rst_i = 1'b0;
        finish_idle;

        // Random walks against the model
        for (int n = 0; n < 40; n++) begin
            logic [31:0] p, v, t;
            logic s;
            int unsigned r;
            int resp;
            p = $urandom; v = $urandom; t = $urandom;
            s = 1'($urandom_range(0, 1));
            r = $urandom_range(0, 9);
            resp = (r < 7) ? RESP_ACK : (r < 9) ? RESP_ERR : RESP_BOTH;
            walk(p, v, s, t, $urandom_range(0, 4), resp, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard bound on simulated time
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
